// File: rtl/dcache_ram_ctrl.sv
// dcache_ram_ctrl: single-port front-end for dcache_data_ram with optional zero-fill after reset
module dcache_ram_ctrl #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 7,
  parameter int NUM_WMASKS    = 8,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_we,
  output logic [DATA_WIDTH-1:0]   resp_rdata,
  output logic                    init_done,
  output logic                    ram_csb,
  output logic                    ram_web,
  output logic [NUM_WMASKS-1:0]   ram_wmask,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);
  typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] cnt, cnt_n, ram_addr_n;
  logic [NUM_WMASKS-1:0] be_mask, ram_wmask_n;
  logic [DATA_WIDTH-1:0] ram_din_n, resp_rdata_n;
  logic we_q, we_q_n, ram_csb_n, ram_web_n, resp_valid_n, resp_we_n, init_done_n;
  logic accept, fill, wr, rd;
  // each byte enable covers two 4-bit mask granules
  for (genvar i = 0; i < NUM_WMASKS; i++) begin : g_mask
    assign be_mask[i] = req_be[i/2];
  end
  assign req_ready = state == IDLE && init_done;
  assign accept    = req_valid && req_ready;
  assign fill      = state == INIT;
  assign wr        = accept && req_we && |req_be;
  assign rd        = accept && !req_we;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT_ON_RESET ? INIT : IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    unique case (state)
      INIT:    state_n = &cnt ? IDLE : INIT;
      IDLE:    state_n = accept ? ISSUE : IDLE;
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = RESP;
      RESP:    state_n = resp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  // a store with no enabled bytes still walks the FSM but never touches the macro
  always_comb begin
    ram_csb_n    = !(fill || wr || rd);
    ram_web_n    = !(fill || wr);
    ram_wmask_n  = fill ? '1 : wr ? be_mask : '0;
    ram_din_n    = wr ? req_wdata : '0;
    ram_addr_n   = fill ? cnt : accept ? req_addr : ram_addr;
    cnt_n        = fill ? cnt + 1'b1 : cnt;
    we_q_n       = accept ? req_we : we_q;
    resp_valid_n = state == WAIT || (state == RESP && !resp_ready);
    resp_we_n    = state == WAIT ? we_q : resp_we;
    resp_rdata_n = state == WAIT ? (we_q ? '0 : ram_dout) : resp_rdata;
    init_done_n  = fill ? &cnt : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_csb    <= 1'b1;
      ram_web    <= 1'b1;
      ram_wmask  <= '0;
      ram_addr   <= '0;
      ram_din    <= '0;
      cnt        <= '0;
      we_q       <= 1'b0;
      resp_valid <= 1'b0;
      resp_we    <= 1'b0;
      resp_rdata <= '0;
      init_done  <= 1'b0;
    end else begin
      ram_csb    <= ram_csb_n;
      ram_web    <= ram_web_n;
      ram_wmask  <= ram_wmask_n;
      ram_addr   <= ram_addr_n;
      ram_din    <= ram_din_n;
      cnt        <= cnt_n;
      we_q       <= we_q_n;
      resp_valid <= resp_valid_n;
      resp_we    <= resp_we_n;
      resp_rdata <= resp_rdata_n;
      init_done  <= init_done_n;
    end
  end
endmodule

// File: tb/tb_dcache_ram_ctrl.sv
// tb_dcache_ram_ctrl: directed bench with a behavioural macro, shadow memory and response scoreboard
module tb_dcache_ram_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
  logic [6:0] req_addr = '0;
  logic [3:0] req_be = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_we, init_done, ram_csb, ram_web;
  logic [31:0] resp_rdata, ram_din;
  logic [31:0] ram_dout = '0;
  logic [7:0] ram_wmask;
  logic [6:0] ram_addr;
  int checks = 0, errors = 0;
  typedef struct {logic we; logic [31:0] d;} exp_t;
  exp_t sb[$];
  logic [31:0] sh [128];
  always #5 clk = ~clk;
  dcache_ram_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .NUM_WMASKS(8), .INIT_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_we(resp_we), .resp_rdata(resp_rdata), .init_done(init_done),
    .ram_csb(ram_csb), .ram_web(ram_web), .ram_wmask(ram_wmask), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout));
  // macro model: inputs captured at posedge, array accessed on the following negedge
  logic c_csb = 1'b1, c_web = 1'b1, seeded = 1'b0;
  logic [7:0] c_wm = '0;
  logic [6:0] c_a = '0;
  logic [31:0] c_d = '0;
  logic [31:0] mem [128];
  always @(posedge clk) begin
    c_csb <= ram_csb; c_web <= ram_web; c_wm <= ram_wmask; c_a <= ram_addr; c_d <= ram_din;
  end
  always @(negedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < 128; i++) mem[i] = $urandom;
      seeded = 1'b1;
    end
    if (!c_csb) begin
      if (!c_web) begin
        for (int n = 0; n < 8; n++) if (c_wm[n]) mem[c_a][4*n +: 4] = c_d[4*n +: 4];
      end else begin
        ram_dout = mem[c_a];
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic init_check(input string tag);
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      chk(tag, {ram_csb, ram_web, ram_wmask, ram_addr, init_done, req_ready},
          {1'b0, 1'b0, 8'hFF, 7'(k), k == 127, k == 127});
    end
    for (int i = 0; i < 128; i++) sh[i] = '0;
  endtask
  task automatic do_req(input string tag, input logic we, input logic [6:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input logic [7:0] exp_mask, input int hold);
    int n = 0;
    exp_t e;
    logic wr;
    wr = we && be != 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk({tag, " ready"}, 64'(req_ready), 64'(1));
    resp_ready = hold == 0;
    req_valid = 1'b1; req_we = we; req_addr = a; req_be = be; req_wdata = wd;
    if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) sh[a][8*b +: 8] = wd[8*b +: 8];
      e.we = 1'b1; e.d = '0;
    end else begin
      e.we = 1'b0; e.d = sh[a];
    end
    sb.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, " issue"}, {ram_csb, ram_web, ram_wmask, ram_addr, ram_din, req_ready},
        {we && be == 0, !wr, exp_mask, a, wr ? wd : 32'h0, 1'b0});
    @(negedge clk);
    chk({tag, " wait"}, {resp_valid, ram_csb, ram_wmask, ram_din}, {1'b0, 1'b1, 8'h00, 32'h0});
    @(negedge clk);
    chk({tag, " sb_nonempty"}, 64'(sb.size() != 0), 64'(1));
    e.we = 1'bx; e.d = 'x;
    if (sb.size() != 0) e = sb.pop_front();
    chk({tag, " resp"}, {resp_valid, resp_we, resp_rdata}, {1'b1, e.we, e.d});
    if (hold > 0) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_be = 4'hF; req_wdata = 32'h5555_5555;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold"}, {resp_valid, req_ready, resp_we, resp_rdata}, {1'b1, 1'b0, e.we, e.d});
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    chk({tag, " done"}, {resp_valid, req_ready}, {1'b0, 1'b1});
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("reset", {ram_csb, ram_web, ram_wmask, ram_addr, ram_din, req_ready, resp_valid, resp_we, resp_rdata, init_done},
        {1'b1, 1'b1, 8'h00, 7'h00, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0});
    rst_n = 1'b1;
    init_check("fill");
    do_req("ld45", 1'b0, 7'h45, 4'h0, 32'h0, 8'h00, 0);
    do_req("st10_full", 1'b1, 7'h10, 4'hF, 32'hDEADBEEF, 8'hFF, 0);
    do_req("ld10_a", 1'b0, 7'h10, 4'h0, 32'h0, 8'h00, 0);
    do_req("st10_b0", 1'b1, 7'h10, 4'h1, 32'h00000012, 8'h03, 0);
    do_req("ld10_b", 1'b0, 7'h10, 4'h0, 32'h0, 8'h00, 0);
    do_req("st10_none", 1'b1, 7'h10, 4'h0, 32'hFFFFFFFF, 8'h00, 0);
    do_req("ld10_c", 1'b0, 7'h10, 4'h0, 32'h0, 8'h00, 0);
    do_req("st20_odd", 1'b1, 7'h20, 4'hA, 32'hA1B2C3D4, 8'hCC, 0);
    do_req("ld20", 1'b0, 7'h20, 4'h0, 32'h0, 8'h00, 0);
    do_req("ld10_hold", 1'b0, 7'h10, 4'h0, 32'h0, 8'h00, 5);
    do_req("ld10_after", 1'b0, 7'h10, 4'h0, 32'h0, 8'h00, 0);
    chk("ready_before_rst", 64'(req_ready), 64'(1));
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'h10; req_be = 4'h0;
    sb.push_back('{1'b0, sh[7'h10]});
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait", {resp_valid, ram_csb, req_ready, init_done, ram_wmask}, {1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    init_check("refill");
    do_req("ld10_zero", 1'b0, 7'h10, 4'h0, 32'h0, 8'h00, 0);
    do_req("ld20_zero", 1'b0, 7'h20, 4'h0, 32'h0, 8'h00, 0);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
